// File: rtl/group_sum_pkg.sv
// Shared definitions for the group-accumulate memory layout: the sequencer states
// and the slot holding each group's sum.
package group_sum_pkg;

   localparam int GROUP_SIZE = 8;
   localparam int NUM_GROUPS = 4;
   localparam int SUM_SLOT   = GROUP_SIZE - 1;
   localparam int GROUP_W    = $clog2(NUM_GROUPS);
   localparam int ADDR_W     = $clog2(GROUP_SIZE * NUM_GROUPS);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_OUTPUT  = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   // The upstream controller writes each sum at the last word of its group.
   function automatic logic [ADDR_W-1:0] sum_addr(input logic [GROUP_W-1:0] group);
      return ADDR_W'(int'(group) * GROUP_SIZE + SUM_SLOT);
   endfunction

endpackage

// File: rtl/group_sum_reader_if.sv
// Memory read port and tagged output stream of the group-sum reader.
interface group_sum_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   import group_sum_pkg::*;

   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_read_enable;
   logic [DATA_WIDTH-1:0] out_data;
   logic [GROUP_W-1:0]    out_group;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      input  mem_data_in,
      output mem_address,
      output mem_read_enable,
      output out_data,
      output out_group,
      output out_valid,
      input  out_ready
   );

   modport slave (
      output mem_data_in,
      input  mem_address,
      input  mem_read_enable,
      input  out_data,
      input  out_group,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/group_sum_reader.sv
// Reads the four stored group sums back after the controller signals ready, streams
// each one out tagged with its group index and keeps a widened grand total.
module group_sum_reader
   import group_sum_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   group_sum_reader_if.master    bus,
   output logic [DATA_WIDTH+1:0] total,
   output logic                  busy,
   output logic                  done
);

   state_e                state_q;
   logic [GROUP_W-1:0]    group_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH+1:0] total_q;
   logic                  rd_en_q;
   logic                  valid_q;
   logic                  busy_q;
   logic                  done_q;

   // Sequencer: state, group pointer, captured sum, running total and output strobes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         group_q <= '0;
         data_q  <= '0;
         total_q <= '0;
         rd_en_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_READ;
                  group_q <= '0;
                  total_q <= '0;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_READ: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // Read data arrives two cycles after the strobe rose, i.e. in CAPTURE.
               state_q <= ST_CAPTURE;
               rd_en_q <= 1'b0;
            end
            ST_CAPTURE: begin
               state_q <= ST_OUTPUT;
               data_q  <= bus.mem_data_in;
               total_q <= total_q + {2'b00, bus.mem_data_in};
               valid_q <= 1'b1;
            end
            ST_OUTPUT: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  if (group_q == GROUP_W'(NUM_GROUPS - 1)) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_READ;
                     group_q <= group_q + GROUP_W'(1);
                     rd_en_q <= 1'b1;
                  end
               end else begin
                  state_q <= ST_OUTPUT;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               group_q <= '0;
               rd_en_q <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_address     = ADDR_WIDTH'(sum_addr(group_q));
   assign bus.mem_read_enable = rd_en_q;
   assign bus.out_data        = data_q;
   assign bus.out_group       = group_q;
   assign bus.out_valid       = valid_q;
   assign total               = total_q;
   assign busy                = busy_q;
   assign done                = done_q;

endmodule

// File: tb/tb_group_sum_reader.sv
// Bench for group_sum_reader: directed table rows with cycle-exact timing, a reset
// sequence, and randomized runs scored against a slot/sum reference model.
module tb_group_sum_reader;

   logic       clock;
   logic       reset;
   logic       start;
   logic [9:0] total;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [32];
   logic       prev_en = 1'b0;

   group_sum_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

   group_sum_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .bus   (bus.master),
      .total (total),
      .busy  (busy),
      .done  (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: real data only in the cycle right after the read strobe falls.
   always begin
      @(posedge clock);
      #1;
      if (prev_en && !bus.mem_read_enable) bus.mem_data_in = mem[bus.mem_address];
      else                                  bus.mem_data_in = 8'($urandom);
      prev_en = bus.mem_read_enable;
   end

   typedef struct {
      int vals [4];
      int stall_grp;
      int stall_len;
      int extra_start;
      bit start_in_done;
      bit chk_timing;
      bit rnd_ready;
      int exp_vc [4];
      int exp_done;
      int exp_total;
   } vec_t;

   vec_t tbl [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_row(input int i, input int a, input int b, input int c, input int d,
                          input int sg, input int sl, input int es, input bit sid,
                          input int c0, input int c1, input int c2, input int c3,
                          input int dn, input int tot);
      tbl[i].vals[0] = a; tbl[i].vals[1] = b; tbl[i].vals[2] = c; tbl[i].vals[3] = d;
      tbl[i].stall_grp = sg; tbl[i].stall_len = sl; tbl[i].extra_start = es;
      tbl[i].start_in_done = sid; tbl[i].chk_timing = 1'b1; tbl[i].rnd_ready = 1'b0;
      tbl[i].exp_vc[0] = c0; tbl[i].exp_vc[1] = c1; tbl[i].exp_vc[2] = c2; tbl[i].exp_vc[3] = c3;
      tbl[i].exp_done = dn; tbl[i].exp_total = tot;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"},  32'(bus.mem_address), 32'd7);
      check({tag, "_rden"},  32'(bus.mem_read_enable), 32'd0);
      check({tag, "_data"},  32'(bus.out_data), 32'd0);
      check({tag, "_group"}, 32'(bus.out_group), 32'd0);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_total"}, 32'(total), 32'd0);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
   endtask

   // One start-to-done transaction; the model is simply the list of slot values in group order.
   task automatic run_seq(input vec_t r);
      logic [7:0] exp_q [$];
      int exp_total = 0;
      int idx = 0;
      int done_c = -1;
      int stall_left = r.stall_len;
      int vc [4] = '{-1, -1, -1, -1};
      bit rdy;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      for (int g = 0; g < 4; g++) begin
         mem[g * 8 + 7] = 8'(r.vals[g]);
         exp_q.push_back(8'(r.vals[g]));
         exp_total += r.vals[g] & 255;
      end
      @(negedge clock);
      start = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clock);
         start = (c == r.extra_start);
         if (bus.out_valid) begin
            if (idx < 4) begin
               check("out_data",  32'(bus.out_data), 32'(exp_q[idx]));
               check("out_group", 32'(bus.out_group), 32'(idx));
               check("mem_addr",  32'(bus.mem_address), 32'(idx * 8 + 7));
               if (vc[idx] < 0) vc[idx] = c;
            end else begin
               check("extra_valid", 32'(bus.out_valid), 32'd0);
            end
         end
         if (done) begin
            done_c = c;
            break;
         end
         check("busy_run", 32'(busy), 32'd1);
         if (bus.out_valid && idx == r.stall_grp && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else if (r.rnd_ready) begin
            rdy = 1'($urandom_range(0, 1));
         end else begin
            rdy = 1'b1;
         end
         bus.out_ready = rdy;
         if (bus.out_valid && rdy) idx++;
      end
      if (done_c < 0) begin
         check("done_timeout", 32'd0, 32'd1);
         start = 1'b0;
      end else begin
         check("handshakes", 32'(idx), 32'd4);
         check("total",      32'(total), 32'(exp_total));
         check("busy_done",  32'(busy), 32'd0);
         if (r.chk_timing) begin
            for (int g = 0; g < 4; g++) check("valid_cycle", 32'(vc[g]), 32'(r.exp_vc[g]));
            check("done_cycle", 32'(done_c), 32'(r.exp_done));
            check("total_tbl",  32'(total), 32'(r.exp_total));
         end
         if (r.start_in_done) start = 1'b1;
         @(negedge clock);
         start = 1'b0;
         check("done_pulse",  32'(done), 32'd0);
         check("busy_after",  32'(busy), 32'd0);
         check("rden_after",  32'(bus.mem_read_enable), 32'd0);
         check("total_hold",  32'(total), 32'(exp_total));
         check("data_hold",   32'(bus.out_data), 32'(exp_q[3]));
      end
   endtask

   task automatic reset_mid();
      bit found = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      @(negedge clock);
      start = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (bus.out_valid && bus.out_group == 2'd2) found = 1'b1;
      end
      if (found) begin
         reset = 1'b0;
         #1;
         check_reset_vals("rst_mid");
         @(negedge clock);
         reset = 1'b1;
      end else begin
         check("reset_mid_reach", 32'd0, 32'd1);
      end
   endtask

   initial begin
      vec_t rv;
      reset = 1'b0;
      start = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clock);
      check_reset_vals("rst_init");
      reset = 1'b1;

      //        idx vals               sg  sl es sid  valid cycles     done total
      set_row(0, 10, 20, 30, 40,       -1, 0, 6, 1,   4,  8, 12, 16,   17, 100);
      set_row(1, 10, 20, 30, 40,        1, 5, 0, 0,   4,  8, 17, 21,   22, 100);
      set_row(2, 255, 255, 255, 255,   -1, 0, 0, 0,   4,  8, 12, 16,   17, 1020);
      set_row(3, 0, 1, 128, 200,        3, 2, 0, 0,   4,  8, 12, 16,   19, 329);

      for (int i = 0; i < 4; i++) run_seq(tbl[i]);

      reset_mid();
      run_seq(tbl[2]);

      for (int n = 0; n < 20; n++) begin
         for (int g = 0; g < 4; g++) rv.vals[g] = int'($urandom_range(0, 255));
         rv.stall_grp     = int'($urandom_range(0, 3));
         rv.stall_len     = int'($urandom_range(0, 4));
         rv.extra_start   = int'($urandom_range(2, 15));
         rv.start_in_done = 1'($urandom_range(0, 1));
         rv.chk_timing    = 1'b0;
         rv.rnd_ready     = 1'b1;
         for (int g = 0; g < 4; g++) rv.exp_vc[g] = 0;
         rv.exp_done  = 0;
         rv.exp_total = 0;
         run_seq(rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
